// File: rtl/fp_narrow_cvt.sv
// -----------------------------------------------------------------------------
// fp_narrow_cvt
// Pipelined floating-point narrowing converter (default 52-bit -> 32-bit).
// Three stages, gated by a common clock enable:
//   S1 decompose/classify, S2 align to the output significand,
//   S3 round, detect overflow and pack.
// Special values bypass rounding. Flags are zero whenever o_vo is zero.
//
// Ports
//   i_clk       clock
//   i_rst       synchronous active-high reset (drops every in-flight op)
//   i_ce        clock enable; every stage register holds while low
//   i_vi        input valid (captured together with i_a and i_rm)
//   i_rm        rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM, 5-7 RNE
//   i_a         operand, FPWID_IN bits
//   o_o         result, FPWID_OUT bits
//   o_vo        result valid
//   o_inexact   rounded result differs from the exact value
//   o_overflow  finite input exceeds the output range after rounding
//   o_underflow tiny before rounding and inexact
//   o_invalid   input was a signalling NaN
// -----------------------------------------------------------------------------
module fp_narrow_cvt #(
    parameter int FPWID_IN  = 52,
    parameter int EXW_IN    = 11,
    parameter int FPWID_OUT = 32,
    parameter int EXW_OUT   = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_ce,
    input  logic                 i_vi,
    input  logic [2:0]           i_rm,
    input  logic [FPWID_IN-1:0]  i_a,
    output logic [FPWID_OUT-1:0] o_o,
    output logic                 o_vo,
    output logic                 o_inexact,
    output logic                 o_overflow,
    output logic                 o_underflow,
    output logic                 o_invalid
);

    localparam int MW_IN    = FPWID_IN - 1 - EXW_IN;
    localparam int MW_OUT   = FPWID_OUT - 1 - EXW_OUT;
    localparam int EW       = EXW_IN + 2;
    localparam int BIAS_IN  = (1 << (EXW_IN - 1)) - 1;
    localparam int BIAS_OUT = (1 << (EXW_OUT - 1)) - 1;
    localparam int SH_MAX   = MW_OUT + 2;
    localparam int SHW      = $clog2(SH_MAX + 1);
    // Hidden bit + mantissa + room for every bit a saturated shift drops.
    localparam int EXT_W    = MW_IN + 1 + SH_MAX;

    localparam logic signed [EW-1:0] REBASE   = EW'(BIAS_OUT - BIAS_IN);
    localparam logic signed [EW-1:0] ONE_S    = EW'(1);
    localparam logic signed [EW-1:0] SH_MAX_S = EW'(SH_MAX);
    localparam logic signed [EW-1:0] EXP_OVF  = EW'((1 << EXW_OUT) - 1);

    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    // ---------------- S1: decompose / classify ----------------
    logic              w_sign;
    logic [EXW_IN-1:0] w_expi;
    logic [MW_IN-1:0]  w_man;
    logic              w_exp_zero, w_exp_ones, w_man_zero;

    assign w_sign     = i_a[FPWID_IN-1];
    assign w_expi     = i_a[FPWID_IN-2 -: EXW_IN];
    assign w_man      = i_a[MW_IN-1:0];
    assign w_exp_zero = (w_expi == {EXW_IN{1'b0}});
    assign w_exp_ones = &w_expi;
    assign w_man_zero = (w_man == {MW_IN{1'b0}});

    logic                 r1_v, r1_sign, r1_zero, r1_den, r1_inf, r1_nan, r1_snan;
    logic [MW_IN-1:0]     r1_man;
    logic signed [EW-1:0] r1_e;
    logic [2:0]           r1_rm;

    // Stage-1 data capture: fields, class and exponent rebased to the output bias.
    always_ff @(posedge i_clk) begin
        if (i_ce) begin
            r1_sign <= w_sign;
            r1_man  <= w_man;
            r1_e    <= $signed({2'b00, w_expi}) + REBASE;
            r1_zero <= w_exp_zero & w_man_zero;
            r1_den  <= w_exp_zero & ~w_man_zero;
            r1_inf  <= w_exp_ones & w_man_zero;
            r1_nan  <= w_exp_ones & ~w_man_zero;
            r1_snan <= w_exp_ones & ~w_man_zero & ~w_man[MW_IN-1];
            r1_rm   <= i_rm;
        end
    end

    // ---------------- S2: align ----------------
    logic signed [EW-1:0] w_neg;
    logic [SHW-1:0]       w_sh;
    logic [EXT_W-1:0]     w_ext;
    logic [EXT_W-2:0]     w_frac;
    logic [MW_OUT-1:0]    w_sig;
    logic                 w_g, w_s, w_tiny;
    logic signed [EW-1:0] w_exp2;

    // Right-shift distance for results below the normal range, saturated so
    // that the whole significand lands in the sticky bits.
    always_comb begin
        w_neg = ONE_S - r1_e;
        w_sh  = {SHW{1'b0}};
        if (r1_e < ONE_S) begin
            if (w_neg > SH_MAX_S) begin
                w_sh = SHW'(SH_MAX);
            end else begin
                w_sh = w_neg[SHW-1:0];
            end
        end else begin
            w_sh = {SHW{1'b0}};
        end
    end

    assign w_ext  = {1'b1, r1_man, {SH_MAX{1'b0}}};
    // The hidden-bit position is dropped: it only matters when unshifted.
    assign w_frac = (EXT_W-1)'(w_ext >> w_sh);

    // Significand, guard and sticky; input denormals collapse to pure sticky.
    always_comb begin
        w_sig  = w_frac[EXT_W-2 -: MW_OUT];
        w_g    = w_frac[EXT_W-2-MW_OUT];
        w_s    = |w_frac[EXT_W-3-MW_OUT:0];
        w_tiny = (r1_e < ONE_S);
        if (r1_den) begin
            w_sig  = {MW_OUT{1'b0}};
            w_g    = 1'b0;
            w_s    = 1'b1;
            w_tiny = 1'b1;
        end else begin
            w_sig  = w_frac[EXT_W-2 -: MW_OUT];
        end
        w_exp2 = w_tiny ? {EW{1'b0}} : r1_e;
    end

    logic                 r2_v, r2_sign, r2_g, r2_s, r2_tiny, r2_zero, r2_inf, r2_nan, r2_snan;
    logic [MW_OUT-1:0]    r2_sig, r2_qman;
    logic signed [EW-1:0] r2_exp;
    logic [2:0]           r2_rm;

    // Stage-2 data capture; NaN payload is kept with its quiet bit forced.
    always_ff @(posedge i_clk) begin
        if (i_ce) begin
            r2_sign <= r1_sign;
            r2_sig  <= w_sig;
            r2_g    <= w_g;
            r2_s    <= w_s;
            r2_exp  <= w_exp2;
            r2_tiny <= w_tiny;
            r2_zero <= r1_zero;
            r2_inf  <= r1_inf;
            r2_nan  <= r1_nan;
            r2_snan <= r1_snan;
            r2_qman <= {1'b1, r1_man[MW_IN-2 -: MW_OUT-1]};
            r2_rm   <= r1_rm;
        end
    end

    // Valid chain through the first two stages.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r1_v <= 1'b0;
            r2_v <= 1'b0;
        end else if (i_ce) begin
            r1_v <= i_vi;
            r2_v <= r1_v;
        end
    end

    // ---------------- S3: round / pack ----------------
    logic                 w_inc, w_ovf_inf;
    logic [MW_OUT:0]      w_sum;
    logic signed [EW-1:0] w_exp_r;
    logic [FPWID_OUT-1:0] w_res;
    logic                 w_inx, w_ovf, w_unf, w_inv;

    // Rounding decision, then special/overflow/finite result selection.
    always_comb begin
        case (r2_rm)
            RM_RTZ:  w_inc = 1'b0;
            RM_RDN:  w_inc = r2_sign & (r2_g | r2_s);
            RM_RUP:  w_inc = ~r2_sign & (r2_g | r2_s);
            RM_RMM:  w_inc = r2_g;
            default: w_inc = r2_g & (r2_s | r2_sig[0]);
        endcase
        case (r2_rm)
            RM_RTZ:  w_ovf_inf = 1'b0;
            RM_RDN:  w_ovf_inf = r2_sign;
            RM_RUP:  w_ovf_inf = ~r2_sign;
            default: w_ovf_inf = 1'b1;
        endcase
        w_sum = {1'b0, r2_sig} + {{MW_OUT{1'b0}}, w_inc};
        // Carry-out bumps the exponent; a denormal carrying out becomes exp 1.
        w_exp_r = $signed(r2_exp + {{(EW-1){1'b0}}, w_sum[MW_OUT]});
        w_res = {FPWID_OUT{1'b0}};
        w_inx = 1'b0;
        w_ovf = 1'b0;
        w_unf = 1'b0;
        w_inv = 1'b0;
        if (r2_nan) begin
            w_res = {r2_sign, {EXW_OUT{1'b1}}, r2_qman};
            w_inv = r2_snan;
        end else if (r2_inf) begin
            w_res = {r2_sign, {EXW_OUT{1'b1}}, {MW_OUT{1'b0}}};
        end else if (r2_zero) begin
            w_res = {r2_sign, {(FPWID_OUT-1){1'b0}}};
        end else if (w_exp_r >= EXP_OVF) begin
            w_ovf = 1'b1;
            w_inx = 1'b1;
            if (w_ovf_inf) begin
                w_res = {r2_sign, {EXW_OUT{1'b1}}, {MW_OUT{1'b0}}};
            end else begin
                w_res = {r2_sign, {(EXW_OUT-1){1'b1}}, 1'b0, {MW_OUT{1'b1}}};
            end
        end else begin
            w_res = {r2_sign, w_exp_r[EXW_OUT-1:0], w_sum[MW_OUT-1:0]};
            w_inx = r2_g | r2_s;
            w_unf = r2_tiny & (r2_g | r2_s);
        end
    end

    // Output registers; result and flags are forced to zero for empty slots.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_o         <= {FPWID_OUT{1'b0}};
            o_vo        <= 1'b0;
            o_inexact   <= 1'b0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
            o_invalid   <= 1'b0;
        end else if (i_ce) begin
            o_o         <= r2_v ? w_res : {FPWID_OUT{1'b0}};
            o_vo        <= r2_v;
            o_inexact   <= r2_v & w_inx;
            o_overflow  <= r2_v & w_ovf;
            o_underflow <= r2_v & w_unf;
            o_invalid   <= r2_v & w_inv;
        end
    end

endmodule

// File: tb/tb_fp_narrow_cvt.sv
// -----------------------------------------------------------------------------
// tb_fp_narrow_cvt
// Directed-vector bench for fp_narrow_cvt with a scoreboard queue. The driver
// pushes hand-computed results tagged with the ce-cycle count at issue; the
// monitor pops on every ce-qualified o_vo and also checks hold behaviour while
// ce is low and that flags stay zero without a valid result.
// Flag vectors are {inexact, overflow, underflow, invalid}.
// -----------------------------------------------------------------------------
module tb_fp_narrow_cvt;

    logic        clk;
    logic        rst;
    logic        ce;
    logic        vi;
    logic [2:0]  rm;
    logic [51:0] a;
    logic [31:0] o;
    logic        vo, inexact, overflow, underflow, invalid;

    fp_narrow_cvt dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_ce        (ce),
        .i_vi        (vi),
        .i_rm        (rm),
        .i_a         (a),
        .o_o         (o),
        .o_vo        (vo),
        .o_inexact   (inexact),
        .o_overflow  (overflow),
        .o_underflow (underflow),
        .o_invalid   (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] eo;
        logic [3:0]  ef;
        int          tag;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   ce_cnt   = 0;
    int   next_id  = 0;

    logic [3:0] flags;
    assign flags = {inexact, overflow, underflow, invalid};

    // Issue one op on the next cycle and record its expected result.
    task automatic issue(input logic [51:0] va, input logic [2:0] vrm,
                         input logic [31:0] eo, input logic [3:0] ef);
        exp_t e;
        @(negedge clk);
        vi = 1'b1;
        a  = va;
        rm = vrm;
        e.eo  = eo;
        e.ef  = ef;
        e.tag = ce_cnt;
        e.id  = next_id;
        next_id++;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            vi = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d required=0", sb.size());
        end
    endtask

    // Monitor: scoreboard pop on new results, hold check while ce is low.
    initial begin
        logic        ce_s, rst_s;
        logic        p_vo;
        logic [31:0] p_o;
        logic [3:0]  p_f;
        exp_t        e;
        p_vo = 1'b0;
        p_o  = 32'h0;
        p_f  = 4'h0;
        forever begin
            @(posedge clk);
            ce_s  = ce;
            rst_s = rst;
            #1;
            if (!rst_s && ce_s) begin
                ce_cnt++;
                if (vo) begin
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_vo o=%h flags=%b required no result", o, flags);
                    end else begin
                        e = sb.pop_front();
                        if (o !== e.eo || flags !== e.ef || ce_cnt != e.tag + 3) begin
                            failures++;
                            $display("FAIL vec%0d o=%h flags=%b latency=%0d required o=%h flags=%b latency=3",
                                     e.id, o, flags, ce_cnt - e.tag, e.eo, e.ef);
                        end
                    end
                end
            end else if (!rst_s && !ce_s) begin
                checks++;
                if (vo !== p_vo || o !== p_o || flags !== p_f) begin
                    failures++;
                    $display("FAIL ce_hold vo=%b o=%h flags=%b required vo=%b o=%h flags=%b",
                             vo, o, flags, p_vo, p_o, p_f);
                end
            end
            if (!rst_s && !vo) begin
                checks++;
                if (flags !== 4'b0000) begin
                    failures++;
                    $display("FAIL flags_without_vo flags=%b required 0000", flags);
                end
            end
            p_vo = vo;
            p_o  = o;
            p_f  = flags;
        end
    end

    initial begin
        rst = 1'b1;
        ce  = 1'b1;
        vi  = 1'b0;
        rm  = 3'd0;
        a   = 52'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (o !== 32'h0 || vo !== 1'b0 || flags !== 4'b0000) begin
            failures++;
            $display("FAIL reset_state o=%h vo=%b flags=%b required o=00000000 vo=0 flags=0000", o, vo, flags);
        end

        // Main function and rounding boundaries.
        issue(52'h3FF0000000000, 3'd0, 32'h3F800000, 4'b0000); // 1.0
        idle(4);
        issue(52'h3FF0000010000, 3'd0, 32'h3F800000, 4'b1000); // half ULP, tie to even
        issue(52'h3FF0000010000, 3'd3, 32'h3F800001, 4'b1000); // RUP
        issue(52'h3FF0000030000, 3'd0, 32'h3F800002, 4'b1000); // tie, odd LSB
        issue(52'h3FF0000010000, 3'd4, 32'h3F800001, 4'b1000); // RMM
        issue(52'hBFF0000010000, 3'd2, 32'hBF800001, 4'b1000); // RDN negative
        issue(52'h3FF0000030000, 3'd7, 32'h3F800002, 4'b1000); // mode 7 acts as RNE
        issue(52'h3F00000000000, 3'd0, 32'h38000000, 4'b0000);
        // Overflow.
        issue(52'h47F0000000000, 3'd0, 32'h7F800000, 4'b1100);
        issue(52'h47F0000000000, 3'd1, 32'h7F7FFFFF, 4'b1100);
        issue(52'hC7F0000000000, 3'd2, 32'hFF800000, 4'b1100);
        issue(52'h47EFFFFFFFFFF, 3'd0, 32'h7F800000, 4'b1100); // rounding carries into overflow
        issue(52'h47EFFFFFFFFFF, 3'd1, 32'h7F7FFFFF, 4'b1000);
        // Underflow / denormal outputs.
        issue(52'h3800000000000, 3'd0, 32'h00400000, 4'b0000);
        issue(52'h37F0000000000, 3'd0, 32'h00200000, 4'b0000);
        issue(52'h380FFFFFFFFFF, 3'd0, 32'h00800000, 4'b1010); // denormal rounds to min normal
        issue(52'h0000000000001, 3'd3, 32'h00000001, 4'b1010); // input denormal, RUP
        issue(52'h8000000000001, 3'd0, 32'h80000000, 4'b1010);
        // Specials.
        issue(52'h7FF0000000001, 3'd0, 32'h7FC00000, 4'b0001);
        issue(52'hFFF0000020000, 3'd1, 32'hFFC00001, 4'b0001);
        issue(52'h7FF8000060000, 3'd0, 32'h7FC00003, 4'b0000);
        issue(52'hFFF0000000000, 3'd0, 32'hFF800000, 4'b0000);
        issue(52'h8000000000000, 3'd3, 32'h80000000, 4'b0000);
        idle(1);
        drain();

        // Back-to-back stream with ce dropped for two cycles mid-stream.
        issue(52'h3FF0000000000, 3'd0, 32'h3F800000, 4'b0000);
        issue(52'h3FF0000030000, 3'd0, 32'h3F800002, 4'b1000);
        issue(52'h47F0000000000, 3'd1, 32'h7F7FFFFF, 4'b1100);
        @(negedge clk);
        vi = 1'b0;
        ce = 1'b0;
        @(negedge clk);
        @(negedge clk);
        ce = 1'b1;
        vi = 1'b1;
        begin
            exp_t e;
            a  = 52'hFFF0000000000;
            rm = 3'd0;
            e.eo = 32'hFF800000; e.ef = 4'b0000; e.tag = ce_cnt; e.id = next_id;
            next_id++;
            sb.push_back(e);
        end
        issue(52'h3800000000000, 3'd0, 32'h00400000, 4'b0000);
        idle(1);
        drain();

        // Reset with two ops in flight: nothing may emerge afterwards.
        @(negedge clk);
        vi = 1'b1;
        a  = 52'h3FF0000000000;
        rm = 3'd0;
        @(negedge clk);
        a  = 52'h47F0000000000;
        @(negedge clk);
        vi  = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (vo !== 1'b0) begin
                failures++;
                $display("FAIL flush_vo cycle=%0d vo=%b required 0", i, vo);
            end
            @(negedge clk);
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_narrow_cvt.md
Name: fp_narrow_cvt

Overview:
- Parametrised, pipelined floating-point narrowing converter. Converts an FPWID_IN-bit IEEE-style value to an FPWID_OUT-bit format.
- Default configuration is 52-bit to 32-bit: in = 1 sign / 11 exp / 40 mantissa; out = 1 / 8 / 23.
- Adds to the basic narrowing conversion: selectable rounding mode, gradual-underflow (denormal) output, NaN payload propagation, exception flags, and a valid pipeline with clock enable.
- Sits in the FPU conversion unit, fed by the issue stage; results and flags go to writeback.

Parameters:
- FPWID_IN, 52, total input width.
- EXW_IN, 11, input exponent width; input mantissa width MW_IN = FPWID_IN-1-EXW_IN.
- FPWID_OUT, 32, total output width.
- EXW_OUT, 8, output exponent width; MW_OUT = FPWID_OUT-1-EXW_OUT. Constraint: EXW_OUT<=EXW_IN, MW_OUT<MW_IN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ce  in  1  clock enable; pipeline holds when 0
- vi  in  1  input valid
- rm  in  3  rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM; 5-7 treated as RNE
- a  in  FPWID_IN  operand
- o  out  FPWID_OUT  result
- vo  out  1  result valid
- inexact  out  1  result differs from exact value
- overflow  out  1  finite input exceeds output range after rounding
- underflow  out  1  tiny (below min normal before rounding) and inexact
- invalid  out  1  input was signalling NaN

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: o=0, vo=0, all flags 0; every pipeline stage valid bit is cleared. Reset mid-operation discards all in-flight ops.
- Pipeline: 3 stages, latency 3 ce-qualified cycles. Throughput is 1 per cycle. When ce=0 all stage registers, including outputs, hold. vo is vi delayed 3 ce cycles. a and rm are captured with vi.
- S1 (decompose/classify):
  - Split a into sign, exponent, mantissa.
  - Classify: zero (exp=0, man=0), input denormal (exp=0, man!=0), inf (exp all 1s, man=0), NaN (exp all 1s, man!=0).
  - sNaN = NaN with mantissa MSB 0.
  - Compute rebased exponent e = expi - BIAS_IN + BIAS_OUT as signed EXW_IN+2 bits, where BIAS = 2^(EXW-1)-1.
- S2 (align):
  - If e>=1: keep normal. Significand = mantissa top MW_OUT bits. Guard = next bit; sticky = OR of the rest.
  - If e<1: shift {1,man} right by 1-e, saturated at MW_OUT+2. Guard/sticky taken from the shifted-out bits; output exp=0; tiny=1.
  - Input denormals are below output range: result is signed zero or the min denormal per rounding; inexact=1, underflow=1.
- S3 (round/pack):
  - Increment decision per mode, with L=LSB, G=guard, S=sticky:
    - RNE: G&(S|L)
    - RTZ: 0
    - RDN: sign&(G|S)
    - RUP: ~sign&(G|S)
    - RMM: G
  - Mantissa carry-out increments the exponent. A denormal rounding up to min normal yields exp=1 and counts as tiny.
  - Overflow (e >= 2^EXW_OUT-1 after rounding): result is inf for RNE/RMM, RUP(+), RDN(-). Otherwise it is max finite (exp all 1s-1, man all 1s). overflow=1, inexact=1.
  - inexact = G|S for finite results.
- Specials bypass rounding:
  - Zero -> signed zero, no flags.
  - Inf -> signed inf, no flags.
  - NaN -> sign kept, exp all 1s, man = input mantissa top MW_OUT bits with MSB forced 1 (quiet). invalid = sNaN. inexact=0.
- Flags are per-result, valid only when vo=1, and 0 when vo=0.

Test Plan:
- Reset then idle -> o=0x00000000, vo=0, flags 0. Assert rst with 2 ops in flight -> vo stays 0 for the next 3 cycles.
- a=0x3FF0000000000 (1.0), rm=RNE, vi for 1 cycle -> 3 cycles later o=0x3F800000, vo=1, flags 0.
- a=0x3FF0000010000 (exact half-ULP): RNE -> o=0x3F800000, inexact=1. RUP -> 0x3F800001. a=0x3FF0000030000, RNE -> 0x3F800002.
- a=0x47F0000000000 (exp 1151): RNE -> 0x7F800000, overflow=1, inexact=1. RTZ -> 0x7F7FFFFF. With sign set and RDN -> 0xFF800000.
- a=0x3800000000000 (2^-127): RNE -> 0x00400000, underflow=0, inexact=0. a=0x7FF0000000001 (sNaN) -> 0x7FC00000, invalid=1. a=0xFFF0000000000 -> 0xFF800000.
- 5 back-to-back ops with ce dropped for 2 cycles mid-stream -> results emerge in order, each held while ce=0. Total 5 vo pulses, no duplicate or lost results.
